// File: rtl/inst_ram_loader_if.sv
// Bus bundle for the instruction RAM loader: load control, byte stream and fetch read port.
interface inst_ram_loader_if #(
   parameter int ADDR_W = 6
);
   logic              load_start;
   logic [ADDR_W-1:0] load_len;
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              busy;
   logic              done;
   logic              cpu_hold;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;

   modport master (
      output load_start, load_len, in_valid, in_byte, rd_addr,
      input  in_ready, busy, done, cpu_hold, rd_data
   );

   modport slave (
      input  load_start, load_len, in_valid, in_byte, rd_addr,
      output in_ready, busy, done, cpu_hold, rd_data
   );
endinterface

// File: rtl/inst_ram_loader.sv
// Instruction RAM with a byte-wide load engine. Bytes are packed little-endian
// into 32-bit words and written sequentially; the CPU is held while loading.
module inst_ram_loader #(
   parameter int ADDR_W = 6
) (
   input logic               clk,
   input logic               rst,
   inst_ram_loader_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] word_ptr;
   logic [ADDR_W-1:0] word_last;
   logic [1:0]        byte_cnt;
   logic [23:0]       asm_buf;
   logic [31:0]       rd_data_q;
   logic [31:0]       mem [0:DEPTH-1];

   logic              xfer;
   logic              last_byte;
   logic              write_en;
   logic              last_word;

   // in_ready is the busy flop itself, so a transfer needs no combinational
   // path from any input back to an output.
   assign xfer      = busy_q && bus.in_valid;
   assign last_byte = (byte_cnt == 2'd3);
   assign write_en  = xfer && last_byte;
   assign last_word = (word_ptr == word_last);

   assign bus.in_ready = busy_q;
   assign bus.busy     = busy_q;
   assign bus.cpu_hold = busy_q;
   assign bus.done     = done_q;
   assign bus.rd_data  = rd_data_q;

   // Next-state logic; load_start only matters while idle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.load_start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (write_en && last_word) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus status flops decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         busy_q <= (state_next == LOAD);
         done_q <= (state_next == DONE);
      end
   end

   // Load pointers and the partial-word assembly buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_ptr  <= '0;
         word_last <= '0;
         byte_cnt  <= 2'd0;
         asm_buf   <= 24'd0;
      end else if (state == IDLE) begin
         if (bus.load_start) begin
            word_last <= bus.load_len;
            word_ptr  <= '0;
            byte_cnt  <= 2'd0;
         end
      end else if (xfer) begin
         case (byte_cnt)
            2'd0:    asm_buf[7:0]   <= bus.in_byte;
            2'd1:    asm_buf[15:8]  <= bus.in_byte;
            2'd2:    asm_buf[23:16] <= bus.in_byte;
            default: asm_buf        <= asm_buf;
         endcase
         byte_cnt <= byte_cnt + 2'd1;
         if (last_byte && !last_word) begin
            word_ptr <= word_ptr + ADDR_W'(1);
         end
      end
   end

   // Word write on the fourth byte; memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[word_ptr] <= {bus.in_byte, asm_buf};
      end
   end

   // Registered fetch read; a same-edge write returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= 32'h0000_0000;
      end else begin
         rd_data_q <= mem[bus.rd_addr];
      end
   end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Testbench for inst_ram_loader: directed loads, scoreboarded fetch reads.
module tb_inst_ram_loader;

   localparam int AW = 6;

   logic clk;
   logic rst;
   logic rd_req;
   logic rd_pend;
   int   checks;
   int   fails;

   logic [31:0] exp_q [$];

   inst_ram_loader_if #(.ADDR_W(AW)) bus ();

   inst_ram_loader #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read requests issued at an edge produce data visible after that edge.
   always @(posedge clk) begin
      rd_pend <= rd_req;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a read result is presented.
   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard underflow", 32'd1, 32'd0);
         end else begin
            checkOutput("rd_data", bus.rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      checkOutput("in_ready before byte", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("done before byte", {31'd0, bus.done}, 32'd0);
      bus.in_valid = 1'b1;
      bus.in_byte  = b;
      tick();
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
   endtask

   task automatic sendWord(input logic [31:0] w, input int maxGap);
      for (int k = 0; k < 4; k++) begin
         int gap;
         gap = $urandom_range(0, maxGap);
         for (int g = 0; g < gap; g++) begin
            tick();
            checkOutput("busy during gap", {31'd0, bus.busy}, 32'd1);
         end
         applyStimulus(w[8*k +: 8]);
      end
   endtask

   task automatic startLoad(input logic [AW-1:0] len);
      bus.load_start = 1'b1;
      bus.load_len   = len;
      tick();
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      checkOutput("busy after start", {31'd0, bus.busy}, 32'd1);
      checkOutput("cpu_hold after start", {31'd0, bus.cpu_hold}, 32'd1);
   endtask

   task automatic issueRead(input logic [AW-1:0] addr, input logic [31:0] expected);
      bus.rd_addr = addr;
      rd_req      = 1'b1;
      exp_q.push_back(expected);
      tick();
      rd_req = 1'b0;
   endtask

   task automatic checkDone();
      checkOutput("done pulse", {31'd0, bus.done}, 32'd1);
      checkOutput("busy with done", {31'd0, bus.busy}, 32'd0);
      checkOutput("in_ready with done", {31'd0, bus.in_ready}, 32'd0);
      tick();
      checkOutput("done cleared", {31'd0, bus.done}, 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #300000;
      fails++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      checks          = 0;
      fails           = 0;
      rst             = 1'b0;
      rd_req          = 1'b0;
      bus.load_start  = 1'b0;
      bus.load_len    = '0;
      bus.in_valid    = 1'b0;
      bus.in_byte     = 8'h00;
      bus.rd_addr     = '0;

      // Asynchronous reset between edges.
      #12;
      rst = 1'b1;
      #1;
      checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
      checkOutput("reset done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset rd_data", bus.rd_data, 32'h0000_0000);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rd_data before first edge", bus.rd_data, 32'h0000_0000);
      tick();

      // Single-word load.
      startLoad(6'd0);
      applyStimulus(8'h13);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      checkDone();
      issueRead(6'd0, 32'h0000_0013);

      // Bytes offered while idle must be refused.
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         checkOutput("idle in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      issueRead(6'd0, 32'h0000_0013);

      // Three-word load with a stray load_start mid-load.
      startLoad(6'd2);
      sendWord(32'h0102_0304, 0);
      bus.load_start = 1'b1;
      bus.load_len   = 6'd5;
      tick();
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      checkOutput("busy after ignored start", {31'd0, bus.busy}, 32'd1);
      sendWord(32'h0506_0708, 1);
      sendWord(32'h1111_1111, 0);
      checkDone();
      issueRead(6'd0, 32'h0102_0304);
      issueRead(6'd1, 32'h0506_0708);
      issueRead(6'd2, 32'h1111_1111);

      // Read-during-write on word 2.
      startLoad(6'd2);
      sendWord(32'hCAFE_F00D, 0);
      sendWord(32'hDEAD_BEEF, 0);
      applyStimulus(8'h22);
      applyStimulus(8'h22);
      applyStimulus(8'h22);
      bus.rd_addr = 6'd2;
      rd_req      = 1'b1;
      exp_q.push_back(32'h1111_1111);
      applyStimulus(8'h22);
      exp_q.push_back(32'h2222_2222);
      checkOutput("done at rdw", {31'd0, bus.done}, 32'd1);
      tick();
      rd_req = 1'b0;
      issueRead(6'd0, 32'hCAFE_F00D);
      issueRead(6'd1, 32'hDEAD_BEEF);

      // Full 64-word load with random valid gaps.
      startLoad(6'd63);
      for (int i = 0; i < 64; i++) begin
         sendWord(32'hA500_0000 | i, 2);
      end
      checkDone();
      for (int i = 0; i < 64; i++) begin
         issueRead(i[AW-1:0], 32'hA500_0000 | i);
      end

      // Abort a 6-word load two bytes into word 3.
      startLoad(6'd5);
      for (int i = 0; i < 3; i++) begin
         sendWord(32'h3C00_0000 | i, 0);
      end
      applyStimulus(8'hEE);
      applyStimulus(8'hEE);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("abort in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("abort cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("idle after abort", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         issueRead(i[AW-1:0], 32'h3C00_0000 | i);
      end
      issueRead(6'd3, 32'hA500_0003);
      issueRead(6'd4, 32'hA500_0004);
      issueRead(6'd5, 32'hA500_0005);

      tick();
      tick();
      checkOutput("scoreboard drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/inst_ram_loader.md
# inst_ram_loader

Instruction memory with a byte-wide load port: 64 x 32-bit words, written by a load engine that assembles a byte stream into little-endian words, and read by the fetch side through a registered read port addressed by word index, PC[7:2]. It sits between a host byte source (UART receiver or test bench) and the CPU fetch path. It holds the CPU while a program is loaded, then releases it.

## Interface
Parameters:
- ADDR_W, 6, word-address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  one-cycle request to begin a load.
- load_len  in  ADDR_W  number of words to load minus 1 (0 -> 1 word, 63 -> 64 words); sampled with load_start.
- in_valid  in  1  byte-stream valid.
- in_byte  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last word has been written.
- cpu_hold  out  1  equals busy; fetch logic holds the PC in reset while high.
- rd_addr  in  ADDR_W  fetch word address.
- rd_data  out  32  fetch data, registered.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0, busy=0. When load_start=1, capture load_len into word_last, clear word_ptr and byte_cnt, and go to LOAD.
- LOAD: in_ready=1, busy=1. A byte transfers only on an edge where in_valid and in_ready are both 1.
  - Byte k of a word (byte_cnt = 0..3) goes to bits [8k+7:8k], so the first byte is the LSB.
  - byte_cnt is 2 bits and wraps 3 -> 0.
  - On the transfer with byte_cnt=3, the assembled word (including the current in_byte) is written to mem[word_ptr] on that same edge.
  - If word_ptr == word_last, go to DONE. Otherwise word_ptr increments.
- DONE: in_ready=0, busy=0, done=1 for exactly one cycle, then IDLE.
- load_start is ignored in LOAD and DONE.
- Memory contents are not cleared by rst. Words not written by a load keep their prior contents.
- Read port:
  - rd_data <= mem[rd_addr] on every rising edge, in every state.
  - A read and a write to the same address on the same edge returns the OLD word.
- in_byte is ignored when in_valid=0. No partial word is ever written.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, cpu_hold=0, done=0, rd_data=32'h0000_0000, word_ptr=0, byte_cnt=0.
- Mid-load reset: load aborts immediately. Words already written remain; the partial word is discarded.
- load_start at edge N: busy and in_ready are 1 after edge N, so the first byte can transfer at edge N+1.
- A full-rate load of W words takes 4W transfer edges. done is high during the cycle after the edge that writes the last word, and busy is 0 in that same cycle.
- Read latency: 1 cycle, rd_addr at edge N -> rd_data valid after edge N.
- A word written at edge N is readable with rd_addr presented at edge N+1 or later.
- in_valid may drop at any point. byte_cnt and word_ptr hold while no transfer occurs.
- busy, cpu_hold, in_ready and done are driven directly by flops; no combinational path from inputs.

## Test plan
- Reset check: assert rst asynchronously, between edges -> all outputs take their reset values immediately. Release rst, drive rd_addr=0 -> rd_data holds its reset value until the first edge, then shows mem[0].
- Single-word load: load_start with load_len=0, then bytes 0x13,0x00,0x00,0x00 back-to-back -> mem[0]=32'h0000_0013; done pulses exactly one cycle after the 4th byte; then a read of addr 0 returns 32'h0000_0013.
- Full load with gaps: load_len=63, 256 bytes with random in_valid gaps, word i = 32'hA5000000|i -> every address 0..63 reads back the expected word; busy is high throughout; no extra writes.
- Ignored requests: pulse load_start mid-load with load_len=5 -> original length still honoured. Bytes presented while IDLE -> in_ready=0 and memory unchanged.
- Read-during-write: hold rd_addr=2 while word 2 (old 0x11111111, new 0x22222222) is written -> rd_data=0x11111111 after the write edge, 0x22222222 one edge later.
- Abort: assert rst after 2 bytes of word 3 of a 6-word load -> words 0..2 hold new data; word 3 is unchanged; state returns to IDLE.
